// File: rtl/traffic_pkg.sv
// Shared types for the traffic light controller: phase encoding, lamp codes
// and the lamp decode used by the top-level output registers.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_NS_G  = 3'd0,
    ST_NS_Y  = 3'd1,
    ST_AR_NS = 3'd2,
    ST_EW_G  = 3'd3,
    ST_EW_Y  = 3'd4,
    ST_AR_EW = 3'd5,
    ST_FLASH = 3'd6
  } state_e;

  // Lamp codes are {R,Y,G}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Returns {ns_lamps, ew_lamps} for a phase; flash_on selects lit/dark in FLASH.
  function automatic logic [5:0] lamps_of(input state_e st, input logic flash_on);
    logic [5:0] res;
    case (st)
      ST_NS_G:  res = {LAMP_GRN, LAMP_RED};
      ST_NS_Y:  res = {LAMP_YEL, LAMP_RED};
      ST_EW_G:  res = {LAMP_RED, LAMP_GRN};
      ST_EW_Y:  res = {LAMP_RED, LAMP_YEL};
      ST_FLASH: res = flash_on ? {LAMP_YEL, LAMP_YEL} : {LAMP_OFF, LAMP_OFF};
      default:  res = {LAMP_RED, LAMP_RED};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser with an armed rising-edge pulse. The edge detector only
// arms once a genuine synchronised low has been seen after reset.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic       r_armed;
  logic       r_rise;
  logic [1:0] r_fill;

  // Synchroniser chain, pipeline-fill tracker, arm flag and registered edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_rise  <= 1'b0;
      r_fill  <= 2'b00;
    end else begin
      r_meta  <= i_d;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_fill  <= {r_fill[0], 1'b1};
      // r_sync holds a real sample only once the chain has filled
      r_armed <= r_armed | (r_fill[1] & ~r_sync);
      r_rise  <= r_sync & ~r_prev & r_armed;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_rise;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection controller: per-second phase countdown, pedestrian
// walk service during all-red, and a flashing-yellow mode when disabled.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_SEC     = 30,
  parameter int YELLOW_SEC    = 3,
  parameter int ALLRED_SEC    = 2,
  parameter int PED_GREEN_SEC = 10,
  parameter int PED_WALK_SEC  = 8,
  parameter int CNT_W         = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clk_1hz,
  input  logic             enable,
  input  logic             ped_req,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             ped_walk,
  output logic [CNT_W-1:0] countdown
);

  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_GREEN     = CNT_W'(GREEN_SEC);
  localparam logic [CNT_W-1:0] C_YELLOW    = CNT_W'(YELLOW_SEC);
  localparam logic [CNT_W-1:0] C_ALLRED    = CNT_W'(ALLRED_SEC);
  localparam logic [CNT_W-1:0] C_PED_GREEN = CNT_W'(PED_GREEN_SEC);
  localparam logic [CNT_W-1:0] C_PED_WALK  = CNT_W'(PED_WALK_SEC);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_walk;
  logic             r_pending;
  logic             r_flash_on;
  logic [2:0]       r_ns;
  logic [2:0]       r_ew;

  state_e           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_walk_nxt;
  logic             w_pend_nxt;
  logic             w_flash_nxt;
  logic [5:0]       w_lamps_nxt;
  logic [CNT_W-1:0] w_ar_cnt;
  logic             w_tick;
  logic             w_ped_lvl;
  logic             w_hz_level_unused;
  logic             w_ped_rise_unused;

  sync_edge_det u_hz_sync (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .i_d     (clk_1hz),
    .o_level (w_hz_level_unused),
    .o_rise  (w_tick)
  );

  sync_edge_det u_ped_sync (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .i_d     (ped_req),
    .o_level (w_ped_lvl),
    .o_rise  (w_ped_rise_unused)
  );

  // An all-red phase becomes the walk phase when a request is waiting
  assign w_ar_cnt = r_pending ? C_PED_WALK : C_ALLRED;

  // Next-state, countdown and pedestrian bookkeeping in priority order
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_walk_nxt  = r_walk;
    w_pend_nxt  = r_pending | (w_ped_lvl & (r_state != ST_FLASH));
    w_flash_nxt = r_flash_on;
    if (!enable) begin
      w_state_nxt = ST_FLASH;
      w_cnt_nxt   = '0;
      w_walk_nxt  = 1'b0;
      w_pend_nxt  = 1'b0;
      if (r_state != ST_FLASH) begin
        w_flash_nxt = 1'b1;
      end else if (w_tick) begin
        w_flash_nxt = ~r_flash_on;
      end else begin
        w_flash_nxt = r_flash_on;
      end
    end else if (r_state == ST_FLASH) begin
      w_state_nxt = ST_AR_EW;
      w_cnt_nxt   = C_ALLRED;
      w_walk_nxt  = 1'b0;
      w_pend_nxt  = 1'b0;
      w_flash_nxt = 1'b0;
    end else if (w_tick && (r_cnt == C_ONE)) begin
      case (r_state)
        ST_NS_G: begin
          w_state_nxt = ST_NS_Y;
          w_cnt_nxt   = C_YELLOW;
        end
        ST_NS_Y: begin
          w_state_nxt = ST_AR_NS;
          w_cnt_nxt   = w_ar_cnt;
          w_walk_nxt  = r_pending;
          w_pend_nxt  = 1'b0;
        end
        ST_AR_NS: begin
          w_state_nxt = ST_EW_G;
          w_cnt_nxt   = C_GREEN;
          w_walk_nxt  = 1'b0;
        end
        ST_EW_G: begin
          w_state_nxt = ST_EW_Y;
          w_cnt_nxt   = C_YELLOW;
        end
        ST_EW_Y: begin
          w_state_nxt = ST_AR_EW;
          w_cnt_nxt   = w_ar_cnt;
          w_walk_nxt  = r_pending;
          w_pend_nxt  = 1'b0;
        end
        ST_AR_EW: begin
          w_state_nxt = ST_NS_G;
          w_cnt_nxt   = C_GREEN;
          w_walk_nxt  = 1'b0;
        end
        default: begin
          w_state_nxt = ST_AR_EW;
          w_cnt_nxt   = C_ALLRED;
          w_walk_nxt  = 1'b0;
        end
      endcase
    end else if (((r_state == ST_NS_G) || (r_state == ST_EW_G)) && r_pending &&
                 (r_cnt > C_PED_GREEN)) begin
      // A tick in this cycle is absorbed by the load
      w_cnt_nxt = C_PED_GREEN;
    end else if (w_tick && (r_cnt > C_ONE)) begin
      w_cnt_nxt = r_cnt - C_ONE;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  assign w_lamps_nxt = lamps_of(w_state_nxt, w_flash_nxt);

  // State, countdown and lamp output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_AR_EW;
      r_cnt      <= C_ALLRED;
      r_walk     <= 1'b0;
      r_pending  <= 1'b0;
      r_flash_on <= 1'b0;
      r_ns       <= LAMP_RED;
      r_ew       <= LAMP_RED;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_walk     <= w_walk_nxt;
      r_pending  <= w_pend_nxt;
      r_flash_on <= w_flash_nxt;
      r_ns       <= w_lamps_nxt[5:3];
      r_ew       <= w_lamps_nxt[2:0];
    end
  end

  assign ns_light  = r_ns;
  assign ew_light  = r_ew;
  assign ped_walk  = r_walk;
  assign countdown = r_cnt;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with short phase durations and a
// 20-cycle clk_1hz; every output change is compared to a hand-derived value.
module tb_traffic_light_ctrl;

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LO = 3'b000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        enable;
  logic        ped_req;
  logic        hz_gen = 1'b0;
  logic        hz_level;
  logic        hz_run;
  logic        clk_1hz;
  logic [2:0]  ns_light;
  logic [2:0]  ew_light;
  logic        ped_walk;
  logic [7:0]  countdown;
  logic [14:0] obs;
  logic [14:0] snap;
  int          checks = 0;
  int          errors = 0;

  traffic_light_ctrl #(
    .GREEN_SEC(5), .YELLOW_SEC(2), .ALLRED_SEC(1),
    .PED_GREEN_SEC(2), .PED_WALK_SEC(3), .CNT_W(8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clk_1hz   (clk_1hz),
    .enable    (enable),
    .ped_req   (ped_req),
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .ped_walk  (ped_walk),
    .countdown (countdown)
  );

  always #5 sys_clk = ~sys_clk;
  always #100 hz_gen = ~hz_gen;

  assign clk_1hz = hz_run ? hz_gen : hz_level;
  assign obs     = {ns_light, ew_light, ped_walk, countdown};

  task automatic check_now(input logic [2:0] ens, input logic [2:0] eew, input logic ewalk,
                           input logic [7:0] ecnt, input string tag);
    checks++;
    assert (obs === {ens, eew, ewalk, ecnt}) else begin
      errors++;
      $error("FAIL %s: observed ns=%b ew=%b walk=%b cnt=%0d, expected ns=%b ew=%b walk=%b cnt=%0d",
             tag, ns_light, ew_light, ped_walk, countdown, ens, eew, ewalk, ecnt);
    end
    snap = obs;
  endtask

  // Waits (bounded) for the next output change, then checks it
  task automatic expect_next(input logic [2:0] ens, input logic [2:0] eew, input logic ewalk,
                             input logic [7:0] ecnt, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; (i < 60) && !seen; i++) begin
      @(posedge sys_clk);
      #1;
      if (obs !== snap) seen = 1'b1;
    end
    check_now(ens, eew, ewalk, ecnt, tag);
  endtask

  task automatic ped_pulse();
    ped_req = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1 ped_req = 1'b0;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    enable    = 1'b1;
    ped_req   = 1'b0;
    hz_run    = 1'b1;
    hz_level  = 1'b0;

    // 1: normal cycle from reset
    #12 check_now(LR, LR, 1'b0, 8'd1, "reset");
    #10 sys_rst_n = 1'b1;
    for (int c = 5; c >= 1; c--) expect_next(LG, LR, 1'b0, 8'(c), "t1_ns_g");
    expect_next(LY, LR, 1'b0, 8'd2, "t1_ns_y2");
    expect_next(LY, LR, 1'b0, 8'd1, "t1_ns_y1");
    expect_next(LR, LR, 1'b0, 8'd1, "t1_ar_ns");
    for (int c = 5; c >= 1; c--) expect_next(LR, LG, 1'b0, 8'(c), "t1_ew_g");
    expect_next(LR, LY, 1'b0, 8'd2, "t1_ew_y2");
    expect_next(LR, LY, 1'b0, 8'd1, "t1_ew_y1");
    expect_next(LR, LR, 1'b0, 8'd1, "t1_ar_ew");
    expect_next(LG, LR, 1'b0, 8'd5, "t1_wrap");

    // 3: request at cnt=5 shortens green and gets a walk phase
    ped_pulse();
    expect_next(LG, LR, 1'b0, 8'd2, "t3_short");
    expect_next(LG, LR, 1'b0, 8'd1, "t3_ns_g1");
    expect_next(LY, LR, 1'b0, 8'd2, "t3_ns_y2");
    expect_next(LY, LR, 1'b0, 8'd1, "t3_ns_y1");
    for (int c = 3; c >= 1; c--) expect_next(LR, LR, 1'b1, 8'(c), "t3_walk");
    for (int c = 5; c >= 1; c--) expect_next(LR, LG, 1'b0, 8'(c), "t3_ew_g");
    expect_next(LR, LY, 1'b0, 8'd2, "t3_ew_y2");
    expect_next(LR, LY, 1'b0, 8'd1, "t3_ew_y1");
    expect_next(LR, LR, 1'b0, 8'd1, "t3_ar_ew");

    // 4: late request does not shorten; request during walk waits for next all-red
    for (int c = 5; c >= 2; c--) expect_next(LG, LR, 1'b0, 8'(c), "t4_ns_g");
    ped_pulse();
    expect_next(LG, LR, 1'b0, 8'd1, "t4_ns_g1");
    expect_next(LY, LR, 1'b0, 8'd2, "t4_ns_y2");
    expect_next(LY, LR, 1'b0, 8'd1, "t4_ns_y1");
    expect_next(LR, LR, 1'b1, 8'd3, "t4_walk3");
    ped_pulse();
    expect_next(LR, LR, 1'b1, 8'd2, "t4_walk2");
    expect_next(LR, LR, 1'b1, 8'd1, "t4_walk1");
    expect_next(LR, LG, 1'b0, 8'd5, "t4_ew_g5");
    expect_next(LR, LG, 1'b0, 8'd2, "t4_ew_short");
    expect_next(LR, LG, 1'b0, 8'd1, "t4_ew_g1");
    expect_next(LR, LY, 1'b0, 8'd2, "t4_ew_y2");
    expect_next(LR, LY, 1'b0, 8'd1, "t4_ew_y1");
    for (int c = 3; c >= 1; c--) expect_next(LR, LR, 1'b1, 8'(c), "t4_walk_ew");
    expect_next(LG, LR, 1'b0, 8'd5, "t4_ns_g5");

    // 5: flash mode entered mid EW_Y and left again
    for (int c = 4; c >= 1; c--) expect_next(LG, LR, 1'b0, 8'(c), "t5_ns_g");
    expect_next(LY, LR, 1'b0, 8'd2, "t5_ns_y2");
    expect_next(LY, LR, 1'b0, 8'd1, "t5_ns_y1");
    expect_next(LR, LR, 1'b0, 8'd1, "t5_ar_ns");
    for (int c = 5; c >= 1; c--) expect_next(LR, LG, 1'b0, 8'(c), "t5_ew_g");
    expect_next(LR, LY, 1'b0, 8'd2, "t5_ew_y2");
    repeat (5) @(posedge sys_clk);
    #1 enable = 1'b0;
    @(posedge sys_clk);
    #1 check_now(LY, LY, 1'b0, 8'd0, "t5_flash_on");
    expect_next(LO, LO, 1'b0, 8'd0, "t5_flash_off");
    expect_next(LY, LY, 1'b0, 8'd0, "t5_flash_on2");
    expect_next(LO, LO, 1'b0, 8'd0, "t5_flash_off2");
    enable = 1'b1;
    @(posedge sys_clk);
    #1 check_now(LR, LR, 1'b0, 8'd1, "t5_exit");
    expect_next(LG, LR, 1'b0, 8'd5, "t5_ns_g5");

    // 6: async reset mid NS_G discards the pending request
    ped_pulse();
    expect_next(LG, LR, 1'b0, 8'd2, "t6_short");
    repeat (3) @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1 check_now(LR, LR, 1'b0, 8'd1, "t6_async_rst");
    repeat (3) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
    for (int c = 5; c >= 1; c--) expect_next(LG, LR, 1'b0, 8'(c), "t6_ns_g");
    expect_next(LY, LR, 1'b0, 8'd2, "t6_ns_y2");
    expect_next(LY, LR, 1'b0, 8'd1, "t6_ns_y1");
    expect_next(LR, LR, 1'b0, 8'd1, "t6_no_walk");

    // 2: reset released with clk_1hz high gives no tick until a fresh rise
    sys_rst_n = 1'b0;
    hz_level  = 1'b1;
    hz_run    = 1'b0;
    #1 check_now(LR, LR, 1'b0, 8'd1, "t2_reset");
    #20 sys_rst_n = 1'b1;
    repeat (60) @(posedge sys_clk);
    #1 check_now(LR, LR, 1'b0, 8'd1, "t2_held_high");
    hz_level = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1 check_now(LR, LR, 1'b0, 8'd1, "t2_low");
    @(negedge sys_clk);
    hz_level = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 check_now(LR, LR, 1'b0, 8'd1, "t2_latency_hold");
    @(posedge sys_clk);
    #1 check_now(LG, LR, 1'b0, 8'd5, "t2_first_tick");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
